zone_spi_tx: RTL and testbench
==============================

# zone_spi_tx

Downstream consumer of the zone-averaging stage. Captures the per-zone average bytes (one `i_data_en` strobe per zone, ZONES per frame) into a ping-pong buffer. On each frame boundary it serialises the completed frame to the LED/backlight driver over a write-only SPI link (mode 0, MSB first, header byte first). Capture of frame N+1 overlaps transmission of frame N.

## Interface
Parameters:
- `ZONES`, 24: zone bytes per frame.
- `CLK_DIV`, 4: SCLK half-period in `clk` cycles (≥2).
- `HEADER`, 8'hA5: sync byte sent before zone data.

Ports:
- `clk`  in  1: system clock. One clock domain only.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `i_data`  in  8: zone average byte from the upstream stage.
- `i_data_en`  in  1: one-cycle strobe that marks `i_data` as valid.
- `i_v_sync`  in  1: frame sync, active-high. Its rising edge marks a frame boundary.
- `spi_sclk`  out  1: SPI clock. Idles low.
- `spi_mosi`  out  1: SPI data.
- `spi_cs_n`  out  1: chip select, active-low.
- `o_busy`  out  1: high from CS assertion to the end of CS_HOLD.
- `o_frame_done`  out  1: one-cycle pulse when a frame transmission completes.
- `o_drop`  out  1: one-cycle pulse when a captured frame is discarded.

## Operation
- **Capture:**
  - Write pointer `wr_cnt` (0..ZONES) stores `i_data` into the capture bank at index `wr_cnt` on each `i_data_en`, then increments.
  - Strobes after `wr_cnt==ZONES` are ignored and set sticky `ovf`.
- **Frame boundary** (rising edge of the registered `i_v_sync`):
  - If `wr_cnt==ZONES` and `ovf==0` and the TX FSM is IDLE: swap banks, start TX.
  - Otherwise: pulse `o_drop` and do not swap.
  - In all cases: clear `wr_cnt` and `ovf`.
- **A strobe coinciding with the boundary cycle** is written as index 0 of the new frame.
- **TX FSM states:**
  - IDLE → CS_SETUP on start.
  - CS_SETUP (CLK_DIV cycles, cs_n low, sclk low) → SHIFT.
  - SHIFT: sends HEADER, then bank[0..ZONES-1], then the checksum if enabled. After the last bit's falling edge → CS_HOLD.
  - CS_HOLD (CLK_DIV cycles, sclk low) → DONE.
  - DONE (1 cycle: cs_n high, `o_frame_done`=1) → IDLE.
- **SHIFT details:**
  - Byte counter and bit counter (7 down to 0).
  - MOSI is updated when sclk goes low and when SHIFT is entered. The receiver samples on the sclk rising edge.
- **Reset mid-transfer:** all state returns to reset values immediately. The next start requires a full captured frame.

## Timing
- Reset values: `spi_sclk`=0, `spi_mosi`=0, `spi_cs_n`=1, `o_busy`=0, `o_frame_done`=0, `o_drop`=0, `wr_cnt`=0, `ovf`=0, FSM=IDLE, both banks 0.
- Start latency: `spi_cs_n` falls 2 clk after the first cycle `i_v_sync` is sampled high. One cycle is the sync register; one is the FSM.
- SCLK period is 2·CLK_DIV cycles. The first rising edge comes CLK_DIV cycles after SHIFT entry.
- Bytes per frame B = ZONES+1 (ZONES+2 with checksum).
- Frame length from cs_n fall to cs_n rise = CLK_DIV + B·8·2·CLK_DIV + CLK_DIV. Defaults: 4 + 1600 + 4 = 1608 cycles.
- `o_busy` covers exactly the cs_n-low interval. `o_frame_done` occurs on the cycle after cs_n returns high.

## Configuration
- `ZONE_SPI_CHECKSUM_EN`:
  - Defined: append one byte equal to the XOR of HEADER and all ZONES data bytes, computed during capture. B = ZONES+2.
  - Undefined: no checksum logic. B = ZONES+1.

## Structure
- **Shared package** `zone_pkg`:
  - TX state enum (IDLE, CS_SETUP, SHIFT, CS_HOLD, DONE).
  - Default constants ZONES_DEF=24, SPI_HEADER=8'hA5.
  - Counter-width function clog2.
- **Sub-module** `spi_byte_shifter`:
  - Loads a byte and produces sclk/mosi over 8 bits with CLK_DIV pacing.
  - Signals `byte_done`.
  - The top level owns the banks, capture and FSM.

## Test plan
- **Nominal frame:** 24 strobes with data 0x01..0x18, then a v_sync rise → cs_n low 2 cycles later. Sampled MOSI = A5,01,02,…,18. cs_n high 1608 cycles after falling. `o_frame_done` pulses once.
- **Short frame:** 23 strobes then v_sync → `o_drop` pulse, cs_n stays high. The next full frame of 24×0x55 transmits correctly.
- **Overflow:** 25 strobes (25th = 0xFF) then v_sync → `o_drop`, no transfer. `ovf` is cleared for the following frame.
- **Overlap:**
  - Frame A (all 0x11) starts TX; frame B (all 0x22) is captured during TX.
  - v_sync before A completes → `o_drop`.
  - The next boundary after A is done with a full frame C (0x33) → C is transmitted with no corruption of A.
- **Reset mid-SHIFT:** assert rst_n=0 at byte 5 → cs_n=1 and sclk=0 in the same cycle. After release, a new full frame transmits from HEADER.
- **Checksum** (`ZONE_SPI_CHECKSUM_EN`): data 0x01..0x18 → final byte = 0xA5 XOR (0x01^…^0x18) = 0xA5^0x18 = 0xBD. Frame length 1672 cycles.

Source files
------------

// File: rtl/zone_pkg.sv
// Shared types and constants for the zone-average SPI transmitter and its byte shifter.
package zone_pkg;

    localparam int unsigned ZONES_DEF  = 24;
    localparam logic [7:0]  SPI_HEADER = 8'hA5;

    typedef enum logic [2:0] {
        StIdle,
        StCsSetup,
        StShift,
        StCsHold,
        StDone
    } tx_state_e;

    // Bits needed to encode 0..value-1, never less than one.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(value)) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// Shifts one byte out MSB first as SPI mode 0: MOSI changes with SCLK low, receiver samples on rise.
module spi_byte_shifter
    import zone_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [7:0] load_data,
    output logic       sclk,
    output logic       mosi,
    output logic       byte_done
);

    localparam int unsigned     DivW    = clog2(CLK_DIV);
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

    logic            active_q, active_d;
    logic [DivW-1:0] div_q, div_d;
    logic            sclk_q, sclk_d;
    logic            mosi_q, mosi_d;
    logic [2:0]      bit_q, bit_d;
    logic [6:0]      shreg_q, shreg_d;
    logic            half_tick;

    assign half_tick = active_q && (div_q == DivLast);
    // Fires on the cycle whose edge produces the falling SCLK of bit 0, so a reload is seamless.
    assign byte_done = half_tick && sclk_q && (bit_q == 3'd0);
    assign sclk      = sclk_q;
    assign mosi      = mosi_q;

    always_comb begin
        active_d = active_q;
        div_d    = div_q;
        sclk_d   = sclk_q;
        mosi_d   = mosi_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        if (load) begin
            active_d = 1'b1;
            div_d    = '0;
            sclk_d   = 1'b0;
            mosi_d   = load_data[7];
            shreg_d  = load_data[6:0];
            bit_d    = 3'd7;
        end else if (half_tick) begin
            div_d  = '0;
            sclk_d = ~sclk_q;
            if (sclk_q) begin
                if (bit_q == 3'd0) begin
                    active_d = 1'b0;
                end else begin
                    bit_d   = bit_q - 3'd1;
                    mosi_d  = shreg_q[6];
                    shreg_d = {shreg_q[5:0], 1'b0};
                end
            end
        end else if (active_q) begin
            div_d = div_q + DivW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q <= 1'b0;
            div_q    <= '0;
            sclk_q   <= 1'b0;
            mosi_q   <= 1'b0;
            bit_q    <= 3'd0;
            shreg_q  <= 7'd0;
        end else begin
            active_q <= active_d;
            div_q    <= div_d;
            sclk_q   <= sclk_d;
            mosi_q   <= mosi_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
        end
    end

endmodule

// File: rtl/zone_spi_tx.sv
// Ping-pong capture of per-zone bytes and framed SPI transmission of each completed frame.
// Optional trailing XOR checksum byte is enabled by defining ZONE_SPI_CHECKSUM_EN.
module zone_spi_tx
    import zone_pkg::*;
#(
    parameter int unsigned ZONES   = ZONES_DEF,
    parameter int unsigned CLK_DIV = 4,
    parameter logic [7:0]  HEADER  = SPI_HEADER
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] i_data,
    input  logic       i_data_en,
    input  logic       i_v_sync,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       o_busy,
    output logic       o_frame_done,
    output logic       o_drop
);

`ifdef ZONE_SPI_CHECKSUM_EN
    localparam int unsigned NBytes = ZONES + 2;
`else
    localparam int unsigned NBytes = ZONES + 1;
`endif
    localparam int unsigned WrW   = clog2(ZONES + 1);
    localparam int unsigned ZIdxW = clog2(ZONES);
    localparam int unsigned ByteW = clog2(NBytes);
    localparam int unsigned DivW  = clog2(CLK_DIV);

    localparam logic [WrW-1:0]   WrFull   = WrW'(ZONES);
    localparam logic [ByteW-1:0] LastByte = ByteW'(NBytes - 1);
    localparam logic [ByteW-1:0] ZonesB   = ByteW'(ZONES);
    localparam logic [DivW-1:0]  DivLast  = DivW'(CLK_DIV - 1);

    // Capture side
    logic [7:0]     bank_q [2][ZONES];
    logic           cap_sel_q;
    logic           tx_sel;
    logic           wr_sel;
    logic [WrW-1:0] wr_cnt_q;
    logic           ovf_q;
    logic           vs_q, vs_qq;
    logic           boundary, frame_ok, start, drop;

    // Transmit side
    tx_state_e        state_q, state_d;
    logic [DivW-1:0]  cnt_q, cnt_d;
    logic [ByteW-1:0] byte_q, byte_d;
    logic [ByteW-1:0] next_idx;
    logic             load;
    logic [7:0]       load_data;
    logic             byte_done;
    logic             tx_active_d;
    logic             cs_n_q, done_q, drop_q;

    assign boundary = vs_q && !vs_qq;
    assign frame_ok = (wr_cnt_q == WrFull) && !ovf_q;
    assign start    = boundary && frame_ok && (state_q == StIdle);
    assign drop     = boundary && !start;
    assign tx_sel   = ~cap_sel_q;
    // A strobe on the boundary cycle lands in whichever bank captures the new frame.
    assign wr_sel   = cap_sel_q ^ start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 2; b++) begin
                for (int z = 0; z < int'(ZONES); z++) begin
                    bank_q[b][z] <= 8'h00;
                end
            end
            cap_sel_q <= 1'b0;
            wr_cnt_q  <= '0;
            ovf_q     <= 1'b0;
        end else if (boundary) begin
            ovf_q    <= 1'b0;
            wr_cnt_q <= i_data_en ? WrW'(1) : '0;
            if (start) begin
                cap_sel_q <= ~cap_sel_q;
            end
            if (i_data_en) begin
                bank_q[wr_sel][ZIdxW'(0)] <= i_data;
            end
        end else if (i_data_en) begin
            if (wr_cnt_q == WrFull) begin
                ovf_q <= 1'b1;
            end else begin
                bank_q[cap_sel_q][ZIdxW'(wr_cnt_q)] <= i_data;
                wr_cnt_q                            <= wr_cnt_q + WrW'(1);
            end
        end
    end

`ifdef ZONE_SPI_CHECKSUM_EN
    logic [7:0] csum_acc_q;
    logic [7:0] csum_tx_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_acc_q <= 8'h00;
            csum_tx_q  <= 8'h00;
        end else if (boundary) begin
            csum_acc_q <= i_data_en ? i_data : 8'h00;
            if (start) begin
                csum_tx_q <= csum_acc_q ^ HEADER;
            end
        end else if (i_data_en && (wr_cnt_q != WrFull)) begin
            csum_acc_q <= csum_acc_q ^ i_data;
        end
    end
`endif

    // Byte index 0 is the header, 1..ZONES the zone data, ZONES+1 the checksum.
    assign next_idx = (state_q == StCsSetup) ? '0 : byte_q + ByteW'(1);

    always_comb begin
        load_data = HEADER;
        if ((next_idx != '0) && (next_idx <= ZonesB)) begin
            load_data = bank_q[tx_sel][ZIdxW'(next_idx - ByteW'(1))];
        end
`ifdef ZONE_SPI_CHECKSUM_EN
        else if (next_idx > ZonesB) begin
            load_data = csum_tx_q;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        byte_d  = byte_q;
        load    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StCsSetup;
                    cnt_d   = '0;
                end
            end
            StCsSetup: begin
                if (cnt_q == DivLast) begin
                    state_d = StShift;
                    byte_d  = '0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + DivW'(1);
                end
            end
            StShift: begin
                if (byte_done) begin
                    if (byte_q == LastByte) begin
                        state_d = StCsHold;
                        cnt_d   = '0;
                    end else begin
                        byte_d = byte_q + ByteW'(1);
                        load   = 1'b1;
                    end
                end
            end
            StCsHold: begin
                if (cnt_q == DivLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + DivW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign tx_active_d = (state_d == StCsSetup) || (state_d == StShift) || (state_d == StCsHold);

    // Outputs are registered from the next state so chip select never glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            byte_q  <= '0;
            vs_q    <= 1'b0;
            vs_qq   <= 1'b0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            byte_q  <= byte_d;
            vs_q    <= i_v_sync;
            vs_qq   <= vs_q;
            cs_n_q  <= ~tx_active_d;
            done_q  <= (state_d == StDone);
            drop_q  <= drop;
        end
    end

    spi_byte_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (load),
        .load_data (load_data),
        .sclk      (spi_sclk),
        .mosi      (spi_mosi),
        .byte_done (byte_done)
    );

    assign spi_cs_n     = cs_n_q;
    assign o_busy       = ~cs_n_q;
    assign o_frame_done = done_q;
    assign o_drop       = drop_q;

endmodule

// File: tb/tb_zone_spi_tx.sv
// Scoreboard bench for zone_spi_tx: driver queues expected SPI bytes, a monitor decodes and compares.
module tb_zone_spi_tx;

    localparam int unsigned ZONES   = 24;
    localparam int unsigned CLK_DIV = 4;
    localparam logic [7:0]  HDR     = 8'hA5;
`ifdef ZONE_SPI_CHECKSUM_EN
    localparam int unsigned NB = ZONES + 2;
`else
    localparam int unsigned NB = ZONES + 1;
`endif
    localparam int unsigned FRAME_LEN = 2 * CLK_DIV + NB * 16 * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] i_data = 8'h00;
    logic       i_data_en = 1'b0;
    logic       i_v_sync = 1'b0;
    logic       spi_sclk, spi_mosi, spi_cs_n, o_busy, o_frame_done, o_drop;

    zone_spi_tx #(
        .ZONES   (ZONES),
        .CLK_DIV (CLK_DIV),
        .HEADER  (HDR)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_data       (i_data),
        .i_data_en    (i_data_en),
        .i_v_sync     (i_v_sync),
        .spi_sclk     (spi_sclk),
        .spi_mosi     (spi_mosi),
        .spi_cs_n     (spi_cs_n),
        .o_busy       (o_busy),
        .o_frame_done (o_frame_done),
        .o_drop       (o_drop)
    );

    always #5 clk = ~clk;

    logic [7:0]  exp_q[$];
    int unsigned len_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned done_cnt = 0;
    int unsigned drop_cnt = 0;
    int unsigned exp_done = 0;
    int unsigned exp_drop = 0;
    int unsigned rx_bytes = 0;
    int unsigned busy_bad = 0;
    int unsigned sclk_bad = 0;

    function automatic void check(input string name, input int unsigned got,
                                  input int unsigned exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endfunction

    // Monitor: decode SPI on the falling clk edge, well away from the DUT's active edge.
    logic        in_frame = 1'b0;
    logic        sclk_prev = 1'b0;
    logic [7:0]  sh = 8'h00;
    int unsigned nbits = 0;
    int unsigned low_cycles = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            in_frame  = 1'b0;
            sclk_prev = 1'b0;
            nbits     = 0;
        end else begin
            if (o_busy !== !spi_cs_n) busy_bad++;
            if (spi_cs_n && spi_sclk) sclk_bad++;
            if (o_frame_done) done_cnt++;
            if (o_drop) drop_cnt++;
            if (!spi_cs_n) begin
                if (!in_frame) begin
                    in_frame   = 1'b1;
                    low_cycles = 0;
                    nbits      = 0;
                    rx_bytes   = 0;
                end
                low_cycles++;
                if (spi_sclk && !sclk_prev) begin
                    sh = {sh[6:0], spi_mosi};
                    nbits++;
                    if (nbits == 8) begin
                        nbits = 0;
                        rx_bytes++;
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            n_errors++;
                            $display("FAIL mosi_unexpected: got byte 0x%0h, none queued", sh);
                        end else begin
                            check("mosi_byte", sh, exp_q.pop_front());
                        end
                    end
                end
            end else if (in_frame) begin
                in_frame = 1'b0;
                check("bits_left_at_cs_rise", nbits, 0);
                if (len_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL frame_unexpected: got %0d cycles, no frame queued", low_cycles);
                end else begin
                    check("frame_len", low_cycles, len_q.pop_front());
                end
            end
            sclk_prev = spi_sclk;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input logic [7:0] d);
        i_data    = d;
        i_data_en = 1'b1;
        tick(1);
        i_data_en = 1'b0;
        tick(1);
    endtask

    task automatic capture(input logic [7:0] base, input logic [7:0] step, input int n);
        for (int i = 0; i < n; i++) strobe(base + 8'(i) * step);
    endtask

    task automatic expect_frame(input logic [7:0] base, input logic [7:0] step);
        logic [7:0] cs;
        logic [7:0] d;
        cs = HDR;
        exp_q.push_back(HDR);
        for (int i = 0; i < int'(ZONES); i++) begin
            d  = base + 8'(i) * step;
            cs = cs ^ d;
            exp_q.push_back(d);
        end
`ifdef ZONE_SPI_CHECKSUM_EN
        exp_q.push_back(cs);
`endif
        len_q.push_back(FRAME_LEN);
    endtask

    task automatic vsync();
        i_v_sync = 1'b1;
        tick(2);
        i_v_sync = 1'b0;
        tick(2);
    endtask

    task automatic wait_frame(input string name);
        int unsigned k;
        k = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0 || !spi_cs_n) && k < 4000) begin
            tick(1);
            k++;
        end
        check({name, "_completed"}, (k < 4000) ? 1 : 0, 1);
        if (k >= 4000) begin
            exp_q.delete();
            len_q.delete();
        end
        exp_done++;
        tick(3);
        check({name, "_frame_done_count"}, done_cnt, exp_done);
    endtask

    task automatic expect_drop(input string name);
        exp_drop++;
        tick(3);
        check({name, "_drop_count"}, drop_cnt, exp_drop);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int unsigned k;
        tick(3);
        check("rst_cs_n", spi_cs_n, 1);
        check("rst_sclk", spi_sclk, 0);
        check("rst_mosi", spi_mosi, 0);
        check("rst_busy", o_busy, 0);
        check("rst_frame_done", o_frame_done, 0);
        check("rst_drop", o_drop, 0);
        rst_n = 1'b1;
        tick(3);

        // Nominal frame with start-latency check.
        capture(8'h01, 8'h01, 24);
        expect_frame(8'h01, 8'h01);
        i_v_sync = 1'b1;
        tick(1);
        check("start_cs_n_after_1clk", spi_cs_n, 1);
        tick(1);
        check("start_cs_n_after_2clk", spi_cs_n, 0);
        check("start_busy", o_busy, 1);
        i_v_sync = 1'b0;
        wait_frame("nominal");
        check("nominal_no_drop", drop_cnt, exp_drop);

        // Short frame is dropped; following full frame is sent.
        capture(8'h10, 8'h01, 23);
        vsync();
        expect_drop("short");
        check("short_cs_idle", spi_cs_n, 1);
        capture(8'h55, 8'h00, 24);
        expect_frame(8'h55, 8'h00);
        vsync();
        wait_frame("after_short");

        // Overflow is dropped; a strobe on that boundary cycle becomes zone 0 of the next frame.
        capture(8'h40, 8'h01, 24);
        strobe(8'hFF);
        i_v_sync = 1'b1;
        tick(1);
        i_data    = 8'hC0;
        i_data_en = 1'b1;
        tick(1);
        i_data_en = 1'b0;
        i_v_sync  = 1'b0;
        tick(1);
        expect_drop("overflow");
        check("overflow_cs_idle", spi_cs_n, 1);
        capture(8'hC1, 8'h01, 23);
        expect_frame(8'hC0, 8'h01);
        vsync();
        wait_frame("after_overflow");

        // Overlap: B captured during A's transfer is dropped, then C goes out.
        capture(8'h11, 8'h00, 24);
        expect_frame(8'h11, 8'h00);
        vsync();
        capture(8'h22, 8'h00, 24);
        check("overlap_still_busy", o_busy, 1);
        vsync();
        expect_drop("overlap_b");
        wait_frame("overlap_a");
        capture(8'h33, 8'h00, 24);
        expect_frame(8'h33, 8'h00);
        vsync();
        wait_frame("overlap_c");

        // Reset in the middle of the shift phase.
        capture(8'h60, 8'h01, 24);
        expect_frame(8'h60, 8'h01);
        rx_bytes = 0;
        vsync();
        k = 0;
        while (rx_bytes < 5 && k < 2000) begin
            tick(1);
            k++;
        end
        check("midshift_reached_byte5", (k < 2000) ? 1 : 0, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_cs_n", spi_cs_n, 1);
        check("midrst_sclk", spi_sclk, 0);
        check("midrst_busy", o_busy, 0);
        exp_q.delete();
        len_q.delete();
        tick(3);
        rst_n = 1'b1;
        tick(3);
        capture(8'h70, 8'h03, 24);
        expect_frame(8'h70, 8'h03);
        vsync();
        wait_frame("after_reset");

        check("busy_tracks_cs_n", busy_bad, 0);
        check("sclk_idle_outside_cs", sclk_bad, 0);
        check("total_drops", drop_cnt, exp_drop);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
